// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen
//   Enumerates, in ascending numeric order, every WIDTH-bit vector that has
//   exactly k bits set. A run is started with a target count k and hands out
//   one vector per valid/ready handshake until the largest such vector
//   (k ones packed at the MSB end) has been accepted.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : request a run (sampled only while busy=0)
//   count_in   : target number of ones k, captured when start is accepted
//   busy       : high while a run is in progress
//   out_vector : current enumerated vector
//   out_valid  : out_vector is valid
//   out_ready  : consumer ready
//   out_last   : out_vector is the final vector of the run
//   done       : one-cycle pulse after the final handshake
//   err        : one-cycle pulse when a start carries count_in > WIDTH
//   state_dbg  : current FSM state (0=IDLE, 1=SCAN, 2=HOLD)
//
// Handshake: a vector transfers on a rising edge where out_valid && out_ready.
// Once out_valid is high, out_vector and out_last stay constant until that
// transfer; out_valid never depends combinationally on out_ready.

module ones_pattern_gen #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    count_in,
  output logic             busy,
  output logic [WIDTH-1:0] out_vector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done,
  output logic             err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    k;
  logic [CW-1:0]    pop;
  logic [WIDTH-1:0] top;

  // Population count of the current candidate.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + CW'(cand[i]);
    end
  end

  // Largest vector with k ones: the k most significant bits set (zero for k=0).
  // Reaching it ends the run, which also guarantees cand never wraps.
  always_comb begin
    top = '0;
    for (int i = 0; i < WIDTH; i++) begin
      top[i] = (i >= (WIDTH - int'(k)));
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cand       <= '0;
      k          <= '0;
      out_vector <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count_in > CW'(WIDTH)) begin
              err <= 1'b1;
            end else begin
              k     <= count_in;
              cand  <= '0;
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (pop == k) begin
            out_vector <= cand;
            out_valid  <= 1'b1;
            out_last   <= (cand == top);
            state      <= HOLD;
          end else begin
            cand <= cand + WIDTH'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              // Resume the search one past the vector just delivered.
              cand  <= cand + WIDTH'(1);
              state <= SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen
//   Directed bench for ones_pattern_gen (WIDTH=4). A reference model builds the
//   expected vector list of a run by filtering 0..2^W-1 on popcount, and a
//   compare process checks busy/done/err every cycle and every transferred
//   vector against it. Literal expectations pin the model and the latencies.

module tb_ones_pattern_gen;

  localparam int W  = 4;
  localparam int CB = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CB-1:0] count_in;
  logic          busy;
  logic [W-1:0]  out_vector;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          done;
  logic          err;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  ones_pattern_gen #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .count_in   (count_in),
    .busy       (busy),
    .out_vector (out_vector),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .done       (done),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int ready_mode = 0; // 0 high, 1 random backpressure, 2 low, 3 stall on 0101

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void build_run(input int kk, output logic [W-1:0] q[$]);
    q = {};
    for (int v = 0; v < (1 << W); v++) begin
      if ($countones(v) == kk) q.push_back(W'(v));
    end
  endfunction

  // ---------------- ready driver ----------------
  initial begin
    int low_left;
    low_left = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          if (low_left > 0) begin
            out_ready = 1'b0;
            low_left--;
          end else begin
            out_ready = 1'b1;
            low_left = $urandom_range(0, 5);
          end
        end
        2: out_ready = 1'b0;
        3: out_ready = !(out_valid && out_vector == 4'b0101);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [W-1:0] exp_q[$];

  initial begin
    bit           m_busy, m_done, m_err, busy_now;
    bit           prev_stall, prev_hs;
    logic [W-1:0] prev_vec, ev;
    logic         prev_last;
    m_busy = 0; m_done = 0; m_err = 0;
    prev_stall = 0; prev_hs = 0; prev_vec = '0; prev_last = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q = {};
        m_busy = 0; m_done = 0; m_err = 0;
        prev_stall = 0; prev_hs = 0;
        continue;
      end
      check_eq("busy", busy, m_busy);
      check_eq("done", done, m_done);
      check_eq("err", err, m_err);
      if (done) done_cnt++;
      if (prev_hs) check_eq("valid_after_hs", out_valid, 0);
      if (prev_stall) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_vector", out_vector, prev_vec);
        check_eq("stall_last", out_last, prev_last);
      end
      if (!m_busy) check_eq("valid_while_idle", out_valid, 0);

      busy_now = m_busy;
      m_done = 0; m_err = 0; prev_hs = 0;
      if (out_valid && out_ready) begin
        hs_cnt++;
        prev_hs = 1;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_vector", out_vector, -1);
        end else begin
          ev = exp_q.pop_front();
          check_eq("vector", out_vector, ev);
          check_eq("last", out_last, (exp_q.size() == 0) ? 1 : 0);
          if (exp_q.size() == 0) begin
            m_done = 1;
            m_busy = 0;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_vec   = out_vector;
      prev_last  = out_last;
      // A start counts only if the run was idle before this edge.
      if (start && !busy_now) begin
        if (int'(count_in) > W) m_err = 1;
        else begin
          build_run(int'(count_in), exp_q);
          m_busy = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; the start is accepted on the next rising edge (E0).
  task automatic do_start(input int kk);
    start = 1'b1;
    count_in = CB'(kk);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int exp_edges, input string name);
    int n = 0;
    while (!out_valid && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(name, n, exp_edges);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("idle_timeout", (n < 300) ? 1 : 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_k(input int kk, input int lat, input int nvec, input string name);
    int d0, h0;
    do_start(kk);
    d0 = done_cnt;
    h0 = hs_cnt;
    wait_valid(lat, name);
    wait_idle();
    check_eq({name, "_done_pulses"}, done_cnt - d0, 1);
    check_eq({name, "_vectors"}, hs_cnt - h0, nvec);
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, "_vector"}, out_vector, 0);
    check_eq({name, "_valid"}, out_valid, 0);
    check_eq({name, "_last"}, out_last, 0);
    check_eq({name, "_busy"}, busy, 0);
    check_eq({name, "_done"}, done, 0);
    check_eq({name, "_err"}, err, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] mq[$];
    logic [W-1:0] pin2[6];
    logic [W-1:0] pin1[4];
    logic [W-1:0] pin3[4];
    int n, d0, h0;
    pin2 = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};
    pin1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    pin3 = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    rst_n = 1'b0;
    start = 1'b0;
    count_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    check_eq("reset_state_dbg", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pin the model against hand-written sequences.
    build_run(2, mq);
    check_eq("model_k2_size", mq.size(), 6);
    foreach (pin2[i]) check_eq("model_k2", mq[i], pin2[i]);
    build_run(1, mq);
    foreach (pin1[i]) check_eq("model_k1", mq[i], pin1[i]);
    build_run(3, mq);
    foreach (pin3[i]) check_eq("model_k3", mq[i], pin3[i]);
    build_run(0, mq);
    check_eq("model_k0", (mq.size() == 1 && mq[0] == 4'b0000) ? 1 : 0, 1);
    build_run(4, mq);
    check_eq("model_k4", (mq.size() == 1 && mq[0] == 4'b1111) ? 1 : 0, 1);

    // Full runs, ready tied high.
    run_k(2, 4, 6, "k2_first_valid");
    run_k(0, 1, 1, "k0_first_valid");
    run_k(4, 16, 1, "k4_first_valid");

    // Out-of-range count.
    do_start(5);
    check_eq("err_pulse", err, 1);
    check_eq("err_busy", busy, 0);
    check_eq("err_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("err_cleared", err, 0);
    check_eq("err_no_done", done, 0);
    check_eq("err_busy2", busy, 0);
    run_k(1, 2, 4, "k1_first_valid");

    // Random backpressure.
    ready_mode = 1;
    run_k(2, 4, 6, "bp_first_valid");
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Starts while busy and on the final handshake are ignored.
    d0 = done_cnt;
    h0 = hs_cnt;
    do_start(2);
    wait_valid(4, "busy_first_valid");
    start = 1'b1;
    count_in = CB'(1);
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_last) && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("busy_last_seen", (n < 64) ? 1 : 0, 1);
    start = 1'b1;
    count_in = CB'(1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("final_hs_busy", busy, 0);
    check_eq("final_hs_done", done, 1);
    check_eq("busy_run_vectors", hs_cnt - h0, 6);
    run_k(1, 2, 4, "restart_first_valid");
    check_eq("busy_test_done_total", done_cnt - d0, 2);

    // Reset while holding 0101.
    ready_mode = 3;
    do_start(2);
    n = 0;
    while (!(out_valid && out_vector == 4'b0101) && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("hold_0101_seen", (n < 64) ? 1 : 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("hold_0101_stable", out_vector, 4'b0101);
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("no_done_after_reset", done_cnt - d0, 0);
    check_eq("idle_after_reset", busy, 0);
    run_k(3, 8, 4, "k3_first_valid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
